// File: rtl/poker_pkg.sv
// poker_pkg: shared deck constants, card encoding and dealer state type.
// Rank codes 2..14 match the seven-segment display encoding (A = 14).
package poker_pkg;

    localparam logic [5:0] DECK_SIZE = 6'd52;
    localparam logic [3:0] RANKS     = 4'd13;
    localparam logic [3:0] RANK_MIN  = 4'd2;
    localparam logic [3:0] RANK_ACE  = 4'd14;

    typedef struct packed {
        logic [1:0] suit;
        logic [3:0] rank;
    } card_t;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        SHUF,
        READY
    } dealer_state_t;

    // All-ones mask just wide enough to cover i (width ceil(log2(i+1))).
    function automatic logic [5:0] shuf_mask(input logic [5:0] i);
        logic [5:0] m;
        if (i[5])      m = 6'h3F;
        else if (i[4]) m = 6'h1F;
        else if (i[3]) m = 6'h0F;
        else if (i[2]) m = 6'h07;
        else if (i[1]) m = 6'h03;
        else if (i[0]) m = 6'h01;
        else           m = 6'h00;
        return m;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, taps 16,14,13,11.
// Ports:
//   clk      - clock
//   reset_n  - asynchronous active-low reset, loads SEED (must be nonzero)
//   value    - current LFSR state
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [15:0] value
);

    logic [15:0] lfsr_q;
    logic        feedback;

    assign feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], feedback};
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/card_dealer.sv
// card_dealer: builds a 52-card deck, shuffles it in place with an
// LFSR-driven Fisher-Yates pass and deals one card per Deal strobe.
// Ports:
//   Clk        - system clock
//   Reset_n    - asynchronous active-low reset
//   Shuffle    - strobe: rebuild and shuffle the deck
//   Deal       - strobe: pop the next card
//   Ready      - deck shuffled, dealing allowed
//   CardValid  - one-cycle pulse, Rank/Suit carry a new card
//   Rank/Suit  - last dealt card (held until the next valid deal)
//   CardsLeft  - undealt cards remaining
//   Underflow  - one-cycle pulse, Deal seen with an empty deck
module card_dealer
    import poker_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter bit          NO_SHUFFLE = 1'b0
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Shuffle,
    input  logic       Deal,
    output logic       Ready,
    output logic       CardValid,
    output logic [3:0] Rank,
    output logic [1:0] Suit,
    output logic [5:0] CardsLeft,
    output logic       Underflow
);

    dealer_state_t state_q, state_d;
    logic [5:0]    idx_q, idx_d;          // k while building, i while shuffling
    logic [3:0]    rank_cnt_q, rank_cnt_d;
    logic [1:0]    suit_cnt_q, suit_cnt_d;
    logic [5:0]    ptr_q, ptr_d;
    logic [5:0]    left_q, left_d;
    logic [3:0]    rank_q, rank_d;
    logic [1:0]    suit_q, suit_d;
    logic          valid_q, valid_d;
    logic          uflow_q, uflow_d;

    card_t         deck_q [DECK_SIZE];
    card_t         cur_card;
    logic          init_wr;
    logic          swap_en;
    logic [5:0]    shuf_j;
    logic [15:0]   lfsr_value;
    logic          unused_lfsr;

    lfsr16 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk    (Clk),
        .reset_n(Reset_n),
        .value  (lfsr_value)
    );

    assign unused_lfsr = ^lfsr_value[15:6];
    assign shuf_j      = lfsr_value[5:0] & shuf_mask(idx_q);
    assign cur_card    = deck_q[ptr_q];

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rank_cnt_d = rank_cnt_q;
        suit_cnt_d = suit_cnt_q;
        ptr_d      = ptr_q;
        left_d     = left_q;
        rank_d     = rank_q;
        suit_d     = suit_q;
        valid_d    = 1'b0;
        uflow_d    = 1'b0;
        init_wr    = 1'b0;
        swap_en    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (Shuffle) begin
                    state_d    = INIT;
                    idx_d      = 6'd0;
                    rank_cnt_d = RANK_MIN;
                    suit_cnt_d = 2'd0;
                end
            end
            INIT: begin
                init_wr = 1'b1;
                idx_d   = idx_q + 6'd1;
                // Rank/suit counters stand in for k mod 13 and k / 13.
                if (rank_cnt_q == RANK_ACE) begin
                    rank_cnt_d = RANK_MIN;
                    suit_cnt_d = suit_cnt_q + 2'd1;
                end else begin
                    rank_cnt_d = rank_cnt_q + 4'd1;
                end
                if (idx_q == DECK_SIZE - 6'd1) begin
                    if (NO_SHUFFLE) begin
                        state_d = READY;
                        ptr_d   = 6'd0;
                        left_d  = DECK_SIZE;
                    end else begin
                        state_d = SHUF;
                        idx_d   = DECK_SIZE - 6'd1;
                    end
                end
            end
            SHUF: begin
                // Out-of-range draws are rejected so every j in 0..i stays equally likely.
                if (shuf_j <= idx_q) begin
                    swap_en = 1'b1;
                    idx_d   = idx_q - 6'd1;
                    if (idx_q == 6'd1) begin
                        state_d = READY;
                        ptr_d   = 6'd0;
                        left_d  = DECK_SIZE;
                    end
                end
            end
            READY: begin
                if (Shuffle) begin
                    state_d    = INIT;
                    idx_d      = 6'd0;
                    rank_cnt_d = RANK_MIN;
                    suit_cnt_d = 2'd0;
                    ptr_d      = 6'd0;
                    left_d     = 6'd0;
                end else if (Deal) begin
                    if (left_q != 6'd0) begin
                        rank_d  = cur_card.rank;
                        suit_d  = cur_card.suit;
                        valid_d = 1'b1;
                        ptr_d   = ptr_q + 6'd1;
                        left_d  = left_q - 6'd1;
                    end else begin
                        uflow_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            idx_q      <= 6'd0;
            rank_cnt_q <= RANK_MIN;
            suit_cnt_q <= 2'd0;
            ptr_q      <= 6'd0;
            left_q     <= 6'd0;
            rank_q     <= 4'd0;
            suit_q     <= 2'd0;
            valid_q    <= 1'b0;
            uflow_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rank_cnt_q <= rank_cnt_d;
            suit_cnt_q <= suit_cnt_d;
            ptr_q      <= ptr_d;
            left_q     <= left_d;
            rank_q     <= rank_d;
            suit_q     <= suit_d;
            valid_q    <= valid_d;
            uflow_q    <= uflow_d;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int n = 0; n < int'(DECK_SIZE); n++) begin
                deck_q[n] <= '0;
            end
        end else if (init_wr) begin
            deck_q[idx_q] <= '{suit: suit_cnt_q, rank: rank_cnt_q};
        end else if (swap_en) begin
            // j == i writes the same value twice, which is harmless.
            deck_q[idx_q]  <= deck_q[shuf_j];
            deck_q[shuf_j] <= deck_q[idx_q];
        end
    end

    assign Ready     = (state_q == READY);
    assign CardValid = valid_q;
    assign Rank      = rank_q;
    assign Suit      = suit_q;
    assign CardsLeft = left_q;
    assign Underflow = uflow_q;

endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: two dealers side by side, one built with NO_SHUFFLE=1
// (build-order deck) and one with the default shuffle.
module tb_card_dealer;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       a_shuf, a_deal, a_ready, a_valid, a_uflow;
    logic [3:0] a_rank;
    logic [1:0] a_suit;
    logic [5:0] a_left;

    logic       b_shuf, b_deal, b_ready, b_valid, b_uflow;
    logic [3:0] b_rank;
    logic [1:0] b_suit;
    logic [5:0] b_left;

    bit         sel;
    logic       o_ready, o_valid, o_uflow;
    logic [3:0] o_rank;
    logic [1:0] o_suit;
    logic [5:0] o_left;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    card_dealer #(
        .LFSR_SEED (16'hACE1),
        .NO_SHUFFLE(1'b1)
    ) dut_ordered (
        .Clk      (clk),
        .Reset_n  (rst_n),
        .Shuffle  (a_shuf),
        .Deal     (a_deal),
        .Ready    (a_ready),
        .CardValid(a_valid),
        .Rank     (a_rank),
        .Suit     (a_suit),
        .CardsLeft(a_left),
        .Underflow(a_uflow)
    );

    card_dealer #(
        .LFSR_SEED (16'hACE1),
        .NO_SHUFFLE(1'b0)
    ) dut_shuffled (
        .Clk      (clk),
        .Reset_n  (rst_n),
        .Shuffle  (b_shuf),
        .Deal     (b_deal),
        .Ready    (b_ready),
        .CardValid(b_valid),
        .Rank     (b_rank),
        .Suit     (b_suit),
        .CardsLeft(b_left),
        .Underflow(b_uflow)
    );

    assign o_ready = sel ? b_ready : a_ready;
    assign o_valid = sel ? b_valid : a_valid;
    assign o_uflow = sel ? b_uflow : a_uflow;
    assign o_rank  = sel ? b_rank  : a_rank;
    assign o_suit  = sel ? b_suit  : a_suit;
    assign o_left  = sel ? b_left  : a_left;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit which, input logic shuf, input logic deal);
        if (which) begin
            b_shuf = shuf;
            b_deal = deal;
        end else begin
            a_shuf = shuf;
            a_deal = deal;
        end
    endtask

    task automatic check_reset(input bit which);
        sel = which;
        #0;
        check("rst_ready", o_ready, 0);
        check("rst_valid", o_valid, 0);
        check("rst_rank", o_rank, 0);
        check("rst_suit", o_suit, 0);
        check("rst_left", o_left, 0);
        check("rst_uflow", o_uflow, 0);
    endtask

    // Waits for Ready, optionally injecting Deal/Shuffle strobes at given cycles.
    task automatic wait_ready(input bit which, input int deal_at, input int shuf_at,
                              output int cycles);
        int stray;
        stray  = 0;
        cycles = 0;
        sel    = which;
        while (cycles < 3000) begin
            step();
            cycles++;
            if (o_valid || o_uflow) stray++;
            if (o_ready) break;
            drive(which, cycles == shuf_at, cycles == deal_at);
        end
        drive(which, 1'b0, 1'b0);
        check("ready_reached", o_ready, 1);
        check("no_stray_pulse", stray, 0);
    endtask

    task automatic run_shuffle(input bit which, input int deal_at, input int shuf_at,
                               output int cycles);
        drive(which, 1'b1, 1'b0);
        wait_ready(which, deal_at, shuf_at, cycles);
    endtask

    // Deals the whole deck with random gaps; in_order selects build-order checking.
    task automatic deal_all(input bit which, input bit in_order);
        bit         seen [52];
        int         dup, oor, in_place, gap_valid, hold_bad, idx;
        logic [3:0] last_r;
        logic [1:0] last_s;
        foreach (seen[n]) seen[n] = 1'b0;
        dup = 0; oor = 0; in_place = 0; gap_valid = 0; hold_bad = 0;
        sel    = which;
        #0;
        last_r = o_rank;
        last_s = o_suit;
        check("deal_start_left", o_left, 52);
        for (int k = 0; k < 52; k++) begin
            repeat ($urandom_range(0, 2)) begin
                step();
                if (o_valid) gap_valid++;
                if (o_rank !== last_r || o_suit !== last_s) hold_bad++;
            end
            drive(which, 1'b0, 1'b1);
            step();
            drive(which, 1'b0, 1'b0);
            if (o_valid !== 1'b1) check("deal_valid", o_valid, 1);
            if (o_left !== 6'(51 - k)) check("deal_left", o_left, 51 - k);
            if (in_order) begin
                check("ordered_rank", o_rank, 2 + k % 13);
                check("ordered_suit", o_suit, k / 13);
            end
            if (o_rank < 4'd2 || o_rank > 4'd14) begin
                oor++;
            end else begin
                idx = int'(o_suit) * 13 + int'(o_rank) - 2;
                if (seen[idx]) dup++;
                seen[idx] = 1'b1;
            end
            if (int'(o_rank) == 2 + k % 13 && int'(o_suit) == k / 13) in_place++;
            last_r = o_rank;
            last_s = o_suit;
        end
        check("gap_no_valid", gap_valid, 0);
        check("gap_hold_card", hold_bad, 0);
        check("rank_in_range", oor, 0);
        check("unique_cards", dup, 0);
        check("left_after_deck", o_left, 0);
        if (!in_order) check("order_shuffled", in_place != 52, 1);

        // Extra Deal on the empty deck.
        drive(which, 1'b0, 1'b1);
        step();
        drive(which, 1'b0, 1'b0);
        check("uflow_pulse", o_uflow, 1);
        check("uflow_no_valid", o_valid, 0);
        check("uflow_rank_hold", o_rank, last_r);
        check("uflow_suit_hold", o_suit, last_s);
        check("uflow_left", o_left, 0);
        step();
        check("uflow_one_cycle", o_uflow, 0);
    endtask

    initial begin
        int cyc;
        rst_n  = 1'b0;
        a_shuf = 1'b0; a_deal = 1'b0;
        b_shuf = 1'b0; b_deal = 1'b0;
        sel    = 1'b0;
        repeat (3) step();
        check_reset(1'b0);
        check_reset(1'b1);
        rst_n = 1'b1;
        step();

        // Build-order deck: latency and full ordered deal.
        run_shuffle(1'b0, -1, -1, cyc);
        check("ns_ready_latency", cyc, 53);
        deal_all(1'b0, 1'b1);

        // Deal + Shuffle together in READY: Shuffle wins.
        run_shuffle(1'b0, -1, -1, cyc);
        drive(1'b0, 1'b1, 1'b1);
        step();
        drive(1'b0, 1'b0, 1'b0);
        check("collide_no_valid", o_valid, 0);
        check("collide_ready_low", o_ready, 0);
        check("collide_left_zero", o_left, 0);
        wait_ready(1'b0, -1, -1, cyc);
        check("collide_relatency", cyc, 52);
        check("collide_left_full", o_left, 52);
        drive(1'b0, 1'b0, 1'b1);
        step();
        drive(1'b0, 1'b0, 1'b0);
        check("collide_first_rank", o_rank, 2);
        check("collide_first_suit", o_suit, 0);

        // Deal and Shuffle strobes during INIT are ignored.
        run_shuffle(1'b0, 5, 20, cyc);
        check("init_ignore_latency", cyc, 53);
        drive(1'b0, 1'b0, 1'b1);
        step();
        drive(1'b0, 1'b0, 1'b0);
        check("init_ignore_valid", o_valid, 1);
        check("init_ignore_left", o_left, 51);

        // Shuffled deck with random start time.
        sel = 1'b1;
        repeat ($urandom_range(0, 20)) step();
        run_shuffle(1'b1, -1, -1, cyc);
        check("shuf_min_latency", cyc >= 103, 1);
        deal_all(1'b1, 1'b0);

        // Deal during INIT, Shuffle during SHUF are ignored.
        run_shuffle(1'b1, 10, 70, cyc);
        check("shuf_ignore_latency", cyc >= 103, 1);
        drive(1'b1, 1'b0, 1'b1);
        step();
        drive(1'b1, 1'b0, 1'b0);
        check("shuf_ignore_valid", o_valid, 1);
        check("shuf_ignore_left", o_left, 51);

        // Reset in the middle of the shuffle pass.
        drive(1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b0);
        repeat (75) step();
        check("mid_shuf_busy", o_ready, 0);
        rst_n = 1'b0;
        #1;
        check_reset(1'b1);
        step();
        rst_n = 1'b1;
        step();
        run_shuffle(1'b1, -1, -1, cyc);
        deal_all(1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
